// File: rtl/neuron_event_sequencer.sv
// Neuron event sequencer.
// Serialises synaptic events and time-reference requests into one-cycle strobes
// for an external combinational neuron, holds the neuron state registers, and
// hands resulting spikes out over a valid/ready port.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous restore of neuron state and counters
//   ev_valid_i/ev_ready_o    synaptic event handshake, ev_weight_i carries the weight
//   tref_valid_i/tref_ready_o  time-reference request handshake
//   syn_event_o, time_ref_o  strobes to the neuron; syn_weight_o is the weight shown to it
//   state_core_o, pre/post_spike_cnt_o       registered neuron state
//   state_core_next_i, pre/post_spike_cnt_next_i, spike_out_i   neuron results
//   spk_valid_o/spk_ready_i  outgoing spike handshake
//   ev_count_o               saturating count of accepted events
`timescale 1ns/1ps

module neuron_event_sequencer #(
   parameter logic [11:0] STATE_INIT = 12'd512,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             ev_valid_i,
   output logic             ev_ready_o,
   input  logic [3:0]       ev_weight_i,
   input  logic             tref_valid_i,
   output logic             tref_ready_o,
   output logic             syn_event_o,
   output logic             time_ref_o,
   output logic [3:0]       syn_weight_o,
   output logic [11:0]      state_core_o,
   output logic [2:0]       pre_spike_cnt_o,
   output logic [2:0]       post_spike_cnt_o,
   input  logic [11:0]      state_core_next_i,
   input  logic [2:0]       pre_spike_cnt_next_i,
   input  logic [2:0]       post_spike_cnt_next_i,
   input  logic             spike_out_i,
   output logic             spk_valid_o,
   input  logic             spk_ready_i,
   output logic [CNT_W-1:0] ev_count_o
);

   typedef enum logic [1:0] {StIdle, StSyn, StTref, StSpk} state_e;

   state_e           state_q;
   logic             ev_rdy_q;
   logic             syn_event_q;
   logic             time_ref_q;
   logic             spk_valid_q;
   logic [3:0]       syn_weight_q;
   logic [11:0]      state_core_q;
   logic [2:0]       pre_cnt_q;
   logic [2:0]       post_cnt_q;
   logic [CNT_W-1:0] ev_count_q;
   logic [CNT_W-1:0] ev_count_d;

   logic ev_accept;
   logic tref_accept;

   // ev_rdy_q is only ever set while idle, so it doubles as the idle-and-ready flag.
   // The only combinational input path: a pending event masks the time reference.
   assign tref_ready_o = ev_rdy_q & ~ev_valid_i;
   assign ev_accept    = ev_rdy_q & ev_valid_i;
   assign tref_accept  = tref_ready_o & tref_valid_i;

   // Saturating increment, no wrap.
   assign ev_count_d = (ev_count_q == {CNT_W{1'b1}}) ? ev_count_q
                                                     : ev_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         ev_rdy_q     <= 1'b0;
         syn_event_q  <= 1'b0;
         time_ref_q   <= 1'b0;
         spk_valid_q  <= 1'b0;
         syn_weight_q <= 4'd0;
         state_core_q <= STATE_INIT;
         pre_cnt_q    <= 3'd0;
         post_cnt_q   <= 3'd0;
         ev_count_q   <= '0;
      end else if (clear_i) begin
         // Clear wins over any same-cycle handshake and abandons a pending spike.
         state_q      <= StIdle;
         ev_rdy_q     <= 1'b0;
         syn_event_q  <= 1'b0;
         time_ref_q   <= 1'b0;
         spk_valid_q  <= 1'b0;
         syn_weight_q <= 4'd0;
         state_core_q <= STATE_INIT;
         pre_cnt_q    <= 3'd0;
         post_cnt_q   <= 3'd0;
         ev_count_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ev_accept) begin
                  state_q      <= StSyn;
                  ev_rdy_q     <= 1'b0;
                  syn_event_q  <= 1'b1;
                  syn_weight_q <= ev_weight_i;
                  ev_count_q   <= ev_count_d;
               end else if (tref_accept) begin
                  state_q      <= StTref;
                  ev_rdy_q     <= 1'b0;
                  syn_event_q  <= 1'b1;
                  time_ref_q   <= 1'b1;
                  syn_weight_q <= 4'd0;
               end else begin
                  // Covers the first idle cycle after reset or clear.
                  ev_rdy_q <= 1'b1;
               end
            end
            StSyn: begin
               state_core_q <= state_core_next_i;
               pre_cnt_q    <= pre_spike_cnt_next_i;
               post_cnt_q   <= post_spike_cnt_next_i;
               syn_event_q  <= 1'b0;
               ev_rdy_q     <= 1'b1;
               state_q      <= StIdle;
            end
            StTref: begin
               state_core_q <= state_core_next_i;
               pre_cnt_q    <= pre_spike_cnt_next_i;
               post_cnt_q   <= post_spike_cnt_next_i;
               syn_event_q  <= 1'b0;
               time_ref_q   <= 1'b0;
               if (spike_out_i) begin
                  state_q     <= StSpk;
                  spk_valid_q <= 1'b1;
               end else begin
                  state_q  <= StIdle;
                  ev_rdy_q <= 1'b1;
               end
            end
            StSpk: begin
               if (spk_ready_i) begin
                  state_q     <= StIdle;
                  spk_valid_q <= 1'b0;
                  ev_rdy_q    <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ev_ready_o       = ev_rdy_q;
   assign syn_event_o      = syn_event_q;
   assign time_ref_o       = time_ref_q;
   assign spk_valid_o      = spk_valid_q;
   assign syn_weight_o     = syn_weight_q;
   assign state_core_o     = state_core_q;
   assign pre_spike_cnt_o  = pre_cnt_q;
   assign post_spike_cnt_o = post_cnt_q;
   assign ev_count_o       = ev_count_q;

endmodule

// File: tb/tb_neuron_event_sequencer.sv
`timescale 1ns/1ps

module tb_neuron_event_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, clear, ev_valid, tref_valid, spk_ready;
   logic [3:0] ev_weight;

   // Primary DUT (CNT_W = 8)
   logic        ev_ready, tref_ready, syn_event, time_ref, spk_valid, spike;
   logic [3:0]  syn_weight;
   logic [11:0] state_core, state_next;
   logic [2:0]  pre_cnt, post_cnt, pre_next, post_next;
   logic [7:0]  ev_count;

   // Twin DUT (CNT_W = 4) for saturation
   logic        ev_ready4, tref_ready4, syn_event4, time_ref4, spk_valid4, spike4;
   logic [3:0]  syn_weight4;
   logic [11:0] state_core4, state_next4;
   logic [2:0]  pre_cnt4, post_cnt4, pre_next4, post_next4;
   logic [3:0]  ev_count4;

   // Bench neuron: next = state + weight; under time_ref fire and reset at >= 100.
   assign spike      = time_ref && (state_core >= 12'd100);
   assign state_next = spike ? 12'd0 : state_core + {8'd0, syn_weight};
   assign pre_next   = pre_cnt + 3'd1;
   assign post_next  = post_cnt + {2'd0, spike};

   assign spike4      = time_ref4 && (state_core4 >= 12'd100);
   assign state_next4 = spike4 ? 12'd0 : state_core4 + {8'd0, syn_weight4};
   assign pre_next4   = pre_cnt4 + 3'd1;
   assign post_next4  = post_cnt4 + {2'd0, spike4};

   neuron_event_sequencer #(.STATE_INIT(12'd512), .CNT_W(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .ev_valid_i(ev_valid), .ev_ready_o(ev_ready), .ev_weight_i(ev_weight),
      .tref_valid_i(tref_valid), .tref_ready_o(tref_ready),
      .syn_event_o(syn_event), .time_ref_o(time_ref), .syn_weight_o(syn_weight),
      .state_core_o(state_core), .pre_spike_cnt_o(pre_cnt), .post_spike_cnt_o(post_cnt),
      .state_core_next_i(state_next), .pre_spike_cnt_next_i(pre_next),
      .post_spike_cnt_next_i(post_next), .spike_out_i(spike),
      .spk_valid_o(spk_valid), .spk_ready_i(spk_ready), .ev_count_o(ev_count)
   );

   neuron_event_sequencer #(.STATE_INIT(12'd512), .CNT_W(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .ev_valid_i(ev_valid), .ev_ready_o(ev_ready4), .ev_weight_i(ev_weight),
      .tref_valid_i(tref_valid), .tref_ready_o(tref_ready4),
      .syn_event_o(syn_event4), .time_ref_o(time_ref4), .syn_weight_o(syn_weight4),
      .state_core_o(state_core4), .pre_spike_cnt_o(pre_cnt4), .post_spike_cnt_o(post_cnt4),
      .state_core_next_i(state_next4), .pre_spike_cnt_next_i(pre_next4),
      .post_spike_cnt_next_i(post_next4), .spike_out_i(spike4),
      .spk_valid_o(spk_valid4), .spk_ready_i(spk_ready), .ev_count_o(ev_count4)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      logic        tref;
      logic [3:0]  weight;
      logic [11:0] state;
      logic [2:0]  pre;
      logic [2:0]  post;
      logic        spike;
      int          cnt;
      int          cnt4;
   } exp_t;

   exp_t        exp_q[$];
   logic [11:0] m_state = 12'd512;
   logic [2:0]  m_pre = 3'd0, m_post = 3'd0;
   int          m_cnt = 0, m_cnt4 = 0;
   int          cyc = 0, prev_acc = -1, ev_cyc = 0, tref_cyc = 0, flush_cnt = 0;
   bit          chk_gap = 0, hold_req = 0;

   // Watches handshakes at the clock edge and predicts each strobe's outcome.
   initial begin
      exp_t e;
      bit   sp;
      forever begin
         @(posedge clk);
         cyc++;
         hold_req = rst_n && !clear && spk_valid && !spk_ready;
         if (rst_n) begin
            if (ev_valid) check("tref_ready_masked_by_event", int'(tref_ready), 0);
            if (syn_event || spk_valid) begin
               check("ev_ready_busy", int'(ev_ready), 0);
               check("tref_ready_busy", int'(tref_ready), 0);
            end
            check("twin_lockstep", int'({ev_ready4, tref_ready4, syn_event4, spk_valid4}),
                  int'({ev_ready, tref_ready, syn_event, spk_valid}));
         end
         if (!rst_n || clear) begin
            m_state = 12'd512; m_pre = 3'd0; m_post = 3'd0; m_cnt = 0; m_cnt4 = 0;
            prev_acc = -1; flush_cnt++; exp_q.delete();
         end else if (ev_valid && ev_ready) begin
            if (chk_gap && prev_acc >= 0) check("burst_accept_gap", cyc - prev_acc, 2);
            prev_acc = cyc; ev_cyc = cyc;
            m_state = m_state + 12'(ev_weight);
            m_pre   = m_pre + 3'd1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
            e = '{tref: 1'b0, weight: ev_weight, state: m_state, pre: m_pre, post: m_post,
                  spike: 1'b0, cnt: m_cnt, cnt4: m_cnt4};
            exp_q.push_back(e);
         end else if (tref_valid && tref_ready) begin
            tref_cyc = cyc;
            sp = (m_state >= 12'd100);
            if (sp) m_state = 12'd0;
            m_pre  = m_pre + 3'd1;
            m_post = m_post + {2'd0, sp};
            e = '{tref: 1'b1, weight: 4'd0, state: m_state, pre: m_pre, post: m_post,
                  spike: sp, cnt: m_cnt, cnt4: m_cnt4};
            exp_q.push_back(e);
         end
      end
   end

   // Monitor: pops an expectation whenever a strobe is presented.
   initial begin
      exp_t p;
      bit   pend = 0;
      int   pend_flush = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend = 0;
         end else begin
            if (hold_req) check("spk_valid_held", int'(spk_valid), 1);
            if (pend && pend_flush == flush_cnt) begin
               check("state_core_after", int'(state_core), int'(p.state));
               check("pre_cnt_after", int'(pre_cnt), int'(p.pre));
               check("post_cnt_after", int'(post_cnt), int'(p.post));
               check("spk_valid_after", int'(spk_valid), int'(p.spike));
            end
            pend = 0;
            if (syn_event) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_strobe", int'(syn_event), 0);
               end else begin
                  p = exp_q.pop_front();
                  check("time_ref", int'(time_ref), int'(p.tref));
                  check("syn_weight", int'(syn_weight), int'(p.weight));
                  check("ev_count", int'(ev_count), p.cnt);
                  check("ev_count4", int'(ev_count4), p.cnt4);
                  pend = 1;
                  pend_flush = flush_cnt;
               end
            end else if (exp_q.size() != 0) begin
               check("missing_strobe", int'(syn_event), 1);
               exp_q.delete();
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // All drivers run just after a rising edge.
   task automatic wait_accept(input bit is_tref, input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(is_tref ? tref_ready : ev_ready) && n < 40);
      if (!(is_tref ? tref_ready : ev_ready)) check(nm, 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic drive_ev(input logic [3:0] w);
      ev_valid = 1'b1; ev_weight = w;
      wait_accept(1'b0, "ev_accept_timeout");
      ev_valid = 1'b0;
   endtask

   task automatic drive_tref();
      tref_valid = 1'b1;
      wait_accept(1'b1, "tref_accept_timeout");
      tref_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; ev_valid = 1'b0; ev_weight = 4'd0;
      tref_valid = 1'b0; spk_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_ev_ready", int'(ev_ready), 0);
      check("rst_tref_ready", int'(tref_ready), 0);
      check("rst_syn_event", int'(syn_event), 0);
      check("rst_time_ref", int'(time_ref), 0);
      check("rst_spk_valid", int'(spk_valid), 0);
      check("rst_state_core", int'(state_core), 512);
      check("rst_counts", int'({pre_cnt, post_cnt}), 0);
      check("rst_syn_weight", int'(syn_weight), 0);
      check("rst_ev_count", int'(ev_count), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_before_first_edge", int'(ev_ready), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("ready_after_first_edge", int'(ev_ready), 1);
      @(posedge clk); #1;

      // Single event
      drive_ev(4'd7);
      @(negedge clk);
      check("single_syn_event", int'(syn_event), 1);
      check("single_syn_weight", int'(syn_weight), 7);
      @(negedge clk);
      check("single_syn_event_drop", int'(syn_event), 0);
      check("single_state", int'(state_core), 519);
      @(posedge clk); #1;

      // Burst of 25 with ev_valid held
      do_reset();
      chk_gap = 1'b1;
      repeat (25) drive_ev(4'd7);
      chk_gap = 1'b0;
      @(negedge clk); @(negedge clk);
      check("burst_ev_count", int'(ev_count), 25);
      check("burst_state", int'(state_core), 687);
      @(posedge clk); #1;

      // Fire with spk_ready low; events offered but must not be taken
      spk_ready = 1'b0;
      drive_tref();
      ev_valid = 1'b1; ev_weight = 4'd7;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("fire_spk_valid", int'(spk_valid), 1);
         check("fire_no_accept", int'(ev_ready), 0);
         check("fire_ev_count", int'(ev_count), 25);
      end
      @(posedge clk); #1;
      ev_valid = 1'b0; spk_ready = 1'b1;
      @(posedge clk); #1;
      spk_ready = 1'b0;
      @(negedge clk);
      check("fire_spk_released", int'(spk_valid), 0);
      check("fire_ready_back", int'(ev_ready), 1);
      check("fire_state", int'(state_core), 0);
      @(posedge clk); #1;

      // Collision: event first, time reference two cycles later
      ev_weight = 4'd3; ev_valid = 1'b1; tref_valid = 1'b1;
      wait_accept(1'b0, "coll_ev_timeout");
      ev_valid = 1'b0;
      wait_accept(1'b1, "coll_tref_timeout");
      tref_valid = 1'b0;
      check("collision_gap", tref_cyc - ev_cyc, 2);
      @(posedge clk); #1;

      // Clear collides with an accepted event
      ev_valid = 1'b1; ev_weight = 4'd9; clear = 1'b1;
      @(posedge clk); #1;
      ev_valid = 1'b0; clear = 1'b0;
      @(negedge clk);
      check("clear_ev_count", int'(ev_count), 0);
      check("clear_no_strobe", int'(syn_event), 0);
      check("clear_state", int'(state_core), 512);
      @(posedge clk); #1;

      // Reset mid-SYN
      drive_ev(4'd5);
      rst_n = 1'b0; #1;
      check("abort_syn_strobe", int'(syn_event), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_syn_state", int'(state_core), 512);
      check("abort_syn_pre", int'(pre_cnt), 0);
      @(posedge clk); #1;

      // Saturation on the 4-bit twin, then reset during SPK
      do_reset();
      repeat (20) drive_ev(4'd7);
      @(negedge clk); @(negedge clk);
      check("sat_ev_count8", int'(ev_count), 20);
      check("sat_ev_count4", int'(ev_count4), 15);
      @(posedge clk); #1;
      spk_ready = 1'b0;
      drive_tref();
      @(negedge clk); @(negedge clk);
      check("spk_before_abort", int'(spk_valid), 1);
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      check("abort_spk_immediate", int'(spk_valid), 0);
      @(negedge clk);
      check("abort_spk_state", int'(state_core), 512);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_spk_not_pending", int'(spk_valid), 0);
      check("abort_ready", int'(ev_ready), 1);
      @(posedge clk); #1;

      // Randomised traffic
      do_reset();
      for (int i = 0; i < 1000; i++) begin
         ev_valid   = 1'($urandom_range(0, 1));
         ev_weight  = 4'($urandom_range(0, 15));
         tref_valid = ($urandom_range(0, 3) == 0);
         spk_ready  = 1'($urandom_range(0, 1));
         clear      = ($urandom_range(0, 49) == 0);
         @(posedge clk); #1;
      end
      ev_valid = 1'b0; tref_valid = 1'b0; clear = 1'b0; spk_ready = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      @(negedge clk);
      check("rand_final_state", int'(state_core), int'(m_state));
      check("rand_final_count", int'(ev_count), m_cnt);
      check("rand_final_count4", int'(ev_count4), m_cnt4);
      check("rand_twin_state", int'(state_core4), int'(m_state));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/neuron_event_sequencer.md
NEURON_EVENT_SEQUENCER -- requirements
Module: neuron_event_sequencer

Interface
REQ-001 Parameter STATE_INIT, default 12'd512, membrane state loaded at reset and on clear.
REQ-002 Parameter CNT_W, default 8, width of the accepted-event counter.
REQ-003 CLK  input  1  single clock; all registers on rising edge.
REQ-004 RSTN  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous restore of neuron state and counters.
REQ-006 ev_valid / ev_ready / ev_weight  in / out / in  1/1/4  synaptic event handshake and weight.
REQ-007 tref_valid / tref_ready  in / out  1/1  time-reference request handshake.
REQ-008 syn_event, time_ref  output  1 each  strobes to the combinational neuron.
REQ-009 syn_weight  output  4  weight presented to the neuron.
REQ-010 state_core, pre_spike_cnt, post_spike_cnt  output  12/3/3  registered neuron state to the neuron.
REQ-011 state_core_next, pre_spike_cnt_next, post_spike_cnt_next  input  12/3/3  neuron next-state.
REQ-012 spike_out  input  1  neuron fire flag.
REQ-013 spk_valid / spk_ready  out / in  1/1  output spike handshake.
REQ-014 ev_count  output  CNT_W  events accepted since reset or clear.

Function
REQ-015 The FSM SHALL have states IDLE, SYN, TREF and SPK; reset state is IDLE.
REQ-016 In IDLE, ev_ready SHALL be 1; tref_ready SHALL be 1 only when ev_valid is 0, so an event takes priority over a simultaneous time reference.
REQ-017 IDLE with ev_valid&ev_ready SHALL latch ev_weight into syn_weight and go to SYN.
REQ-018 In SYN (exactly one cycle), syn_event SHALL be 1 and time_ref 0; at the closing edge state_core, pre_spike_cnt and post_spike_cnt SHALL load their _next inputs; next state IDLE.
REQ-019 IDLE with tref_valid&tref_ready SHALL go to TREF.
REQ-020 In TREF (exactly one cycle), syn_event and time_ref SHALL both be 1 and syn_weight 0; at the closing edge the state SHALL load the _next inputs and spike_out SHALL be sampled.
REQ-021 After TREF, a sampled spike_out of 1 SHALL move the FSM to SPK; otherwise it SHALL move to IDLE.
REQ-022 In SPK, spk_valid SHALL be 1 and both ev_ready and tref_ready 0; the FSM SHALL leave to IDLE on the cycle spk_valid&spk_ready.
REQ-023 spk_valid SHALL be 1 only in SPK; it SHALL not drop before spk_ready is seen.
REQ-024 ev_ready and tref_ready SHALL be 0 in SYN and TREF, so throughput is one event per 2 cycles.
REQ-025 ev_count SHALL increment by 1 per accepted event and saturate at all-ones (no wrap).
REQ-026 syn_event, time_ref, spk_valid, ev_ready and tref_ready SHALL be driven from FSM state only, with no combinational path from ev_valid except the tref_ready gating in REQ-016.
REQ-027 If clear and an accepted event occur in the same cycle, clear SHALL win: the event is dropped and ev_count stays 0.
REQ-028 If clear is asserted, the FSM SHALL return to IDLE from any state, including a pending SPK, which SHALL be abandoned.

Reset
REQ-029 RSTN low SHALL immediately set state IDLE, state_core=STATE_INIT, pre/post_spike_cnt=0, syn_weight=0, ev_count=0, and all strobes, readies and spk_valid to 0.
REQ-030 ev_ready SHALL rise on the first CLK edge after RSTN deasserts.
REQ-031 Reset asserted mid-SYN, mid-TREF or mid-SPK SHALL abort the operation, with no state capture and no spike left pending.
REQ-032 clear SHALL have the same effect as reset on the next CLK edge, synchronously.

Verification
REQ-033 The bench SHALL model the neuron as next=state+weight, with spike_out=1 and next=0 under time_ref when state>=param_thr (thr=100).
REQ-034 Scenario, single event: reset, then ev_weight=7 -> syn_event is high for one cycle with syn_weight=7, and state_core becomes 519.
REQ-035 Scenario, burst: 25 back-to-back events of weight 7 with ev_valid held -> one accept every 2 cycles, ev_count=25, and state_core=687.
REQ-036 Scenario, fire: time reference after REQ-035 with spk_ready held 0 for 5 cycles -> spk_valid is held for 5 cycles, no accepts occur, and state_core=0.
REQ-037 Scenario, collision: ev_valid and tref_valid raised together -> the event is served first and the time reference is accepted 2 cycles later.
REQ-038 Scenario, saturation and abort: with CNT_W=4, 20 events leave ev_count=15; RSTN pulsed during SPK leaves spk_valid=0 and state_core=512.
